delay_timer: RTL and testbench
==============================

# delay_timer

Instruction-delay timer for the flow-control sequencer. It sits directly upstream of the program counter. When the instruction at the current PC is a delay instruction, it loads the millisecond duration operand and counts it down on a prescaled 1 ms tick. It then returns the one-cycle `count_done` pulse that lets the PC advance. It also exports busy/remaining status for valve-sequence monitoring.

## Interface
- `TICK_DIV`, default 100000: clk cycles per duration unit (1 ms at 100 MHz); must be ≥ 2.
- `DUR_W`, default 16: width of the duration operand and of `remaining`.
- `clk`  in  1: system clock (100 MHz).
- `rst`  in  1: reset, asynchronous, active-low; it returns the block to IDLE regardless of other inputs.
- `delay`  in  1: the decoded instruction at the current PC is a delay; valid in the same cycle as the PC value.
- `duration`  in  DUR_W: delay length in ticks; sampled only on accept.
- `hold`  in  1: the PC halt request; while high, the block freezes counting and extends DONE.
- `count_done`  out  1: delay complete; feeds the PC's `count_done`.
- `busy`  out  1: high whenever the state is not IDLE.
- `remaining`  out  DUR_W: ticks left in the current delay; 0 when idle.

## Operation
- States: IDLE, COUNT, DONE, REARM.
- Reset values:
  - state = IDLE.
  - `count_done` = 0, `busy` = 0, `remaining` = 0.
  - Prescaler = 0.
- IDLE:
  - With `delay` = 1 and `hold` = 0, the block accepts: `remaining` ← `duration`, prescaler ← 0.
  - Next state is COUNT if `duration` ≠ 0, else DONE.
  - While `hold` = 1, the block does not accept.
- COUNT:
  - The prescaler runs 0..TICK_DIV−1 and wraps.
  - When it wraps, `remaining` decrements.
  - The edge where it wraps with `remaining` = 1 sets `remaining` to 0 and enters DONE.
- DONE: `count_done` = 1 and is registered (`count_done` is 1 exactly in DONE). The next state is REARM, unless `hold` = 1.
- REARM: a single cycle in which `delay` is ignored. It absorbs the instruction-fetch latency after the PC increments. Next state is always IDLE.
- Consecutive delay instructions each get a full, fresh countdown. The earliest re-accept is the IDLE cycle after REARM.
- `count_done` is a pulse by contract: the PC holds on `delay` = 0 with `count_done` = 1, so `count_done` must never stay high outside DONE.

## Timing
- Accept at edge E0 with `duration` = N > 0: `count_done` is high for the single cycle following edge E0 + N·TICK_DIV.
- N = 0: `count_done` is high in the cycle following E0.
- `remaining` updates on the same edge as the prescaler wrap and is registered.
- Boundary conditions:
  - **`hold` in COUNT:** the prescaler and `remaining` freeze. Counting resumes where it stopped, and total latency grows by the number of held cycles.
  - **`hold` in DONE:** the block stays in DONE with `count_done` high until `hold` falls. It leaves DONE on the first edge with `hold` = 0, so the PC, whose halt has priority, never misses the pulse.
  - **`delay` falls in COUNT:** the delay is abandoned (PC reset or program jump). The block returns to IDLE on that edge with `remaining` ← 0 and no `count_done`.
  - **`delay` falls in DONE:** the pulse still completes and the block continues to REARM.
  - **`rst` low mid-operation:** outputs go to reset values immediately (asynchronous). The first accept is possible on the first edge after `rst` rises.
  - **`duration` = max (2^DUR_W − 1):** counts fully; no overflow, since `remaining` only decrements.
  - **Prescaler width:** clog2(TICK_DIV); compares against TICK_DIV−1 at full width, no truncation.

## Structure
- Shared package `delay_pkg`:
  - state encoding constants (IDLE = 0, COUNT = 1, DONE = 2, REARM = 3);
  - default `TICK_DIV` and `DUR_W`.
- Sub-module `tick_prescaler`:
  - ports: `clk`, `rst`, `en` (COUNT and not `hold`), `clr`;
  - output: one-cycle `tick` on wrap;
  - parameter: `TICK_DIV`.
- The top level holds the FSM, the `remaining` register and the output logic.

## Test plan
All scenarios use TICK_DIV = 4 and DUR_W = 16.
- **Basic countdown:** `duration` = 3, `delay` = 1 at E0. Required:
  - `remaining` reads 3, 2, 1, 0 with steps at E4, E8 and E12;
  - `count_done` = 1 only in the cycle after E12;
  - `busy` = 0 again after REARM.
- **Zero duration:** `duration` = 0. Required: `count_done` is high exactly in the cycle after E0, and the block does not visit COUNT.
- **Back-to-back delays:** durations 2 then 1, with `delay` held high throughout. Required: two separate one-cycle `count_done` pulses, the second one REARM + 1 + 4 cycles after the first.
- **Hold:**
  - 3 cycles of `hold` during COUNT → `count_done` is delayed by exactly 3 cycles;
  - 5 cycles of `hold` during DONE → `count_done` is high for 6 cycles, then falls.
- **Abort:** `delay` falls at `remaining` = 2. Required: IDLE on the next edge, `remaining` = 0, no `count_done` for 20 cycles.
- **Reset:** `rst` is pulled low mid-COUNT between clock edges. Required: all outputs read 0 immediately; a new accept is possible after release.

Source files
------------

// File: rtl/delay_pkg.sv
// delay_pkg: shared definitions for the instruction-delay timer.
//   state_e          - FSM state encoding (IDLE=0, COUNT=1, DONE=2, REARM=3)
//   DEFAULT_TICK_DIV - clk cycles per duration unit (1 ms at 100 MHz)
//   DEFAULT_DUR_W    - width of the duration operand and remaining count
package delay_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2,
    REARM = 2'd3
  } state_e;

  localparam int DEFAULT_TICK_DIV = 100000;
  localparam int DEFAULT_DUR_W    = 16;

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running 0..TICK_DIV-1 counter producing the duration tick.
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   en   - advance the counter this cycle (frozen when low)
//   clr  - force the counter back to 0 (takes priority over en)
//   tick - high in the cycle whose edge wraps the counter back to 0
module tick_prescaler
  import delay_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_top;

  // Compare at 32 bits so a TICK_DIV that is not a power of two is never truncated.
  always_comb begin
    at_top = (32'(cnt_q) == (TICK_DIV - 1));
    tick   = en && at_top;
    cnt_d  = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_top ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/delay_timer.sv
// delay_timer: counts down a delay instruction's millisecond operand and returns
// a one-cycle count_done pulse that lets the program counter advance.
//   clk        - system clock
//   rst        - asynchronous active-low reset
//   delay      - current instruction is a delay (also keeps a running delay alive)
//   duration   - delay length in ticks, sampled on accept
//   hold       - PC halt: freezes counting and stretches DONE
//   count_done - high exactly while in DONE
//   busy       - high whenever not IDLE
//   remaining  - ticks left in the current delay, 0 when idle
module delay_timer
  import delay_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV,
  parameter int DUR_W    = DEFAULT_DUR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             delay,
  input  logic [DUR_W-1:0] duration,
  input  logic             hold,
  output logic             count_done,
  output logic             busy,
  output logic [DUR_W-1:0] remaining
);

  state_e           state_q, state_d;
  logic             count_done_q, count_done_d;
  logic             busy_q, busy_d;
  logic [DUR_W-1:0] remaining_q, remaining_d;

  logic tick;
  logic presc_en;
  logic presc_clr;

  // Outside COUNT the prescaler sits at 0, so every countdown starts on a fresh period.
  assign presc_en  = (state_q == COUNT) && !hold;
  assign presc_clr = (state_q != COUNT);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (presc_en),
    .clr (presc_clr),
    .tick(tick)
  );

  // Abort (delay low) wins over hold in COUNT; tick is already gated by hold.
  // Outputs are derived from the next state so they are registered with it.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        remaining_d = '0;
        if (delay && !hold) begin
          remaining_d = duration;
          state_d     = (duration != '0) ? COUNT : DONE;
        end
      end
      COUNT: begin
        if (!delay) begin
          remaining_d = '0;
          state_d     = IDLE;
        end else if (tick) begin
          if (remaining_q == DUR_W'(1)) begin
            remaining_d = '0;
            state_d     = DONE;
          end else begin
            remaining_d = remaining_q - DUR_W'(1);
          end
        end
      end
      DONE: begin
        remaining_d = '0;
        if (!hold) begin
          state_d = REARM;
        end
      end
      REARM: begin
        remaining_d = '0;
        state_d     = IDLE;
      end
      default: begin
        remaining_d = '0;
        state_d     = IDLE;
      end
    endcase
    count_done_d = (state_d == DONE);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      count_done_q <= 1'b0;
      busy_q       <= 1'b0;
      remaining_q  <= '0;
    end else begin
      state_q      <= state_d;
      count_done_q <= count_done_d;
      busy_q       <= busy_d;
      remaining_q  <= remaining_d;
    end
  end

  assign count_done = count_done_q;
  assign busy       = busy_q;
  assign remaining  = remaining_q;

endmodule

// File: tb/tb_delay_timer.sv
// tb_delay_timer: self-checking bench for delay_timer with TICK_DIV=4, DUR_W=16.
// Expected values come from hand-derived vectors and from a cycle-count model
// that tracks elapsed unheld cycles since accept.
module tb_delay_timer;

  localparam int TICK_DIV = 4;
  localparam int DUR_W    = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             delay;
  logic             hold;
  logic [DUR_W-1:0] duration;
  logic             count_done;
  logic             busy;
  logic [DUR_W-1:0] remaining;

  int checks = 0;
  int errors = 0;

  // Reference model state: which phase the delay is in and how many unheld
  // cycles have elapsed since it was accepted.
  bit m_active;
  bit m_done;
  bit m_rearm;
  int m_elapsed;
  int m_dur;

  typedef struct {
    logic d;
    logic h;
    int   dur;
    int   reps;
    logic e_cd;
    logic e_busy;
    int   e_rem;
  } vec_t;

  vec_t vecs[$];

  delay_timer #(
    .TICK_DIV(TICK_DIV),
    .DUR_W   (DUR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .delay     (delay),
    .duration  (duration),
    .hold      (hold),
    .count_done(count_done),
    .busy      (busy),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    m_active  = 1'b0;
    m_done    = 1'b0;
    m_rearm   = 1'b0;
    m_elapsed = 0;
    m_dur     = 0;
  endtask

  task automatic model_step();
    if (m_rearm) begin
      m_rearm = 1'b0;
    end else if (m_done) begin
      if (!hold) begin
        m_done  = 1'b0;
        m_rearm = 1'b1;
      end
    end else if (m_active) begin
      if (!delay) begin
        m_active = 1'b0;
      end else if (!hold) begin
        m_elapsed++;
        if (m_elapsed == m_dur * TICK_DIV) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
    end else if (delay && !hold) begin
      if (duration == '0) begin
        m_done = 1'b1;
      end else begin
        m_active  = 1'b1;
        m_elapsed = 0;
        m_dur     = int'(duration);
      end
    end
  endtask

  function automatic int model_remaining();
    return m_active ? (m_dur - m_elapsed / TICK_DIV) : 0;
  endfunction

  task automatic check_output(input string tag);
    check_val({tag, ".count_done"}, int'(count_done), int'(m_done));
    check_val({tag, ".busy"}, int'(busy), int'(m_active | m_done | m_rearm));
    check_val({tag, ".remaining"}, int'(remaining), model_remaining());
  endtask

  task automatic apply_stimulus(input logic d, input logic h, input int dur);
    delay    = d;
    hold     = h;
    duration = DUR_W'(dur);
  endtask

  // One clock: model advances on the edge, outputs compared on the falling edge.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_output(tag);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int found;
    int highs;
    int diff;
    int pulses[$];

    rst = 1'b0;
    apply_stimulus(1'b0, 1'b0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    check_val("reset.count_done", int'(count_done), 0);
    check_val("reset.busy", int'(busy), 0);
    check_val("reset.remaining", int'(remaining), 0);
    rst = 1'b1;

    // {delay, hold, duration, cycles, count_done, busy, remaining}
    vecs.push_back(vec_t'{1'b1, 1'b0, 3, 1, 1'b0, 1'b1, 3});
    vecs.push_back(vec_t'{1'b1, 1'b0, 3, 3, 1'b0, 1'b1, 3});
    vecs.push_back(vec_t'{1'b1, 1'b0, 3, 1, 1'b0, 1'b1, 2});
    vecs.push_back(vec_t'{1'b1, 1'b0, 3, 4, 1'b0, 1'b1, 1});
    vecs.push_back(vec_t'{1'b1, 1'b0, 3, 3, 1'b0, 1'b1, 1});
    vecs.push_back(vec_t'{1'b1, 1'b0, 3, 1, 1'b1, 1'b1, 0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 0, 1, 1'b0, 1'b1, 0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 0, 1, 1'b0, 1'b0, 0});
    vecs.push_back(vec_t'{1'b1, 1'b0, 0, 1, 1'b1, 1'b1, 0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 0, 1, 1'b0, 1'b1, 0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 0, 1, 1'b0, 1'b0, 0});
    vecs.push_back(vec_t'{1'b1, 1'b1, 5, 2, 1'b0, 1'b0, 0});
    vecs.push_back(vec_t'{1'b1, 1'b0, 1, 1, 1'b0, 1'b1, 1});
    vecs.push_back(vec_t'{1'b1, 1'b0, 1, 4, 1'b1, 1'b1, 0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 0, 5, 1'b1, 1'b1, 0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 0, 1, 1'b0, 1'b1, 0});
    vecs.push_back(vec_t'{1'b1, 1'b0, 7, 1, 1'b0, 1'b0, 0});
    vecs.push_back(vec_t'{1'b1, 1'b0, 7, 1, 1'b0, 1'b1, 7});
    vecs.push_back(vec_t'{1'b0, 1'b0, 7, 1, 1'b0, 1'b0, 0});

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].d, vecs[i].h, vecs[i].dur);
      repeat (vecs[i].reps) cycle("vec_model");
      check_val($sformatf("vec%0d.count_done", i), int'(count_done), int'(vecs[i].e_cd));
      check_val($sformatf("vec%0d.busy", i), int'(busy), int'(vecs[i].e_busy));
      check_val($sformatf("vec%0d.remaining", i), int'(remaining), vecs[i].e_rem);
    end

    // Hold for 3 cycles mid-countdown: duration 2 completes 3 edges late.
    apply_stimulus(1'b1, 1'b0, 2);
    cycle("hold_count");
    found = -1;
    for (int i = 1; i <= 40; i++) begin
      apply_stimulus(1'b1, (i >= 3 && i <= 5), 2);
      cycle("hold_count");
      if (count_done) begin
        found = i;
        break;
      end
    end
    check_val("hold_count.latency", found, 2 * TICK_DIV + 3);
    apply_stimulus(1'b0, 1'b0, 0);
    repeat (3) cycle("hold_count");

    // Back-to-back delays with delay held high: durations 2 then 1.
    pulses.delete();
    apply_stimulus(1'b1, 1'b0, 2);
    for (int i = 0; i < 20; i++) begin
      cycle("b2b");
      if (count_done) pulses.push_back(i);
      if (pulses.size() > 0) apply_stimulus(1'b1, 1'b0, 1);
    end
    check_val("b2b.pulse_cycles", pulses.size(), 2);
    found = (pulses.size() > 0) ? pulses[0] : -1;
    check_val("b2b.first_pulse", found, 2 * TICK_DIV);
    diff = (pulses.size() >= 2) ? (pulses[1] - pulses[0]) : -1;
    check_val("b2b.pulse_gap", diff, 3 + TICK_DIV);
    apply_stimulus(1'b0, 1'b0, 0);
    repeat (6) cycle("b2b");

    // Abort when remaining reaches 2: back to idle, no pulse afterwards.
    apply_stimulus(1'b1, 1'b0, 3);
    cycle("abort");
    repeat (TICK_DIV) cycle("abort");
    check_val("abort.remaining_before", int'(remaining), 2);
    apply_stimulus(1'b0, 1'b0, 0);
    cycle("abort");
    check_val("abort.busy", int'(busy), 0);
    check_val("abort.remaining", int'(remaining), 0);
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      cycle("abort");
      if (count_done) highs++;
    end
    check_val("abort.no_pulse", highs, 0);

    // Maximum duration loads and decrements without wrapping.
    apply_stimulus(1'b1, 1'b0, 65535);
    cycle("maxdur");
    check_val("maxdur.loaded", int'(remaining), 65535);
    repeat (TICK_DIV) cycle("maxdur");
    check_val("maxdur.first_step", int'(remaining), 65534);
    apply_stimulus(1'b0, 1'b0, 0);
    cycle("maxdur");

    // Asynchronous reset between edges mid-countdown.
    apply_stimulus(1'b1, 1'b0, 3);
    cycle("rst_mid");
    repeat (5) cycle("rst_mid");
    #2;
    rst = 1'b0;
    #1;
    check_val("rst_mid.count_done", int'(count_done), 0);
    check_val("rst_mid.busy", int'(busy), 0);
    check_val("rst_mid.remaining", int'(remaining), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(1'b1, 1'b0, 2);
    cycle("rst_mid");
    check_val("rst_mid.reaccept", int'(remaining), 2);
    apply_stimulus(1'b0, 1'b0, 0);
    repeat (3) cycle("rst_mid");

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      apply_stimulus(($urandom_range(0, 15) != 0), ($urandom_range(0, 5) == 0),
                     int'($urandom_range(0, 6)));
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
